adc_spi_responder: RTL and testbench

ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

---
 rtl/adc_spi_pkg.sv | 16 +
 rtl/sync_edge.sv | 34 +++
 rtl/adc_spi_responder.sv | 153 +++++++++++++++
 tb/tb_adc_spi_responder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_pkg.sv
// Shared definitions for the ADC SPI responder: FSM state encoding,
// default frame geometry and the bit index width.
package adc_spi_pkg;

    localparam int DATA_BITS_DEF  = 8;   // sample width
    localparam int LEAD_ZEROS_DEF = 3;   // zero bits sent before the MSB
    localparam int FRAME_BITS_DEF = 16;  // sclk falling edges per frame
    localparam int BIT_IDX_W      = 5;   // holds 0..FRAME_BITS

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_QUIET = 2'd2
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous pin followed by an edge-detect
// flop. rise/fall are single-cycle pulses that the consumer acts on at the
// third clk edge after the pin changes. All flops reset to 1, the idle level
// of both sclk and cs_n, so a quiet bus produces no edge after reset.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Synchronizer chain plus delayed copy for edge detection.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make each flop capture the previous stage's old value; blocking ones would collapse the chain into a single flop.
        if (!reset) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/adc_spi_responder.sv
// ADC emulator on the responder side of an SPI link. Each cs_n low period is
// one conversion frame: the sample (host data, internal ramp, or the previous
// sample on underrun) is shifted out MSB first between LEAD_ZEROS leading and
// trailing zero bits, one bit per sclk falling edge, all in the clk domain.
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int LEAD_ZEROS = LEAD_ZEROS_DEF,
    parameter int FRAME_BITS = FRAME_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sclk,
    input  logic                 cs_n,
    output logic                 sdata,
    output logic                 sdata_oe,
    input  logic [DATA_BITS-1:0] sample_data,
    input  logic                 sample_valid,
    output logic                 sample_ack,
    input  logic                 pattern_en,
    output logic                 conv_done,
    output logic [15:0]          conv_count,
    output logic                 underrun,
    output logic                 frame_error
);

    localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(FRAME_BITS - 1);

    state_t                 state;
    state_t                 state_next;
    logic [BIT_IDX_W-1:0]   bit_idx;
    logic [DATA_BITS-1:0]   sample_q;
    logic [DATA_BITS-1:0]   ramp;

    logic sclk_rise_unused;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;

    logic frame_start;
    logic shift_step;
    logic frame_finish;
    logic frame_abort;
    logic shifting;

    sync_edge u_sync_sclk (
        .clk   (clk),
        .reset (reset),
        .din   (sclk),
        .rise  (sclk_rise_unused),
        .fall  (sclk_fall)
    );

    sync_edge u_sync_cs (
        .clk   (clk),
        .reset (reset),
        .din   (cs_n),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // Serial bit for a given frame position: zeros outside the sample window,
    // otherwise the sample MSB first.
    function automatic logic bit_at(input logic [BIT_IDX_W-1:0] idx,
                                    input logic [DATA_BITS-1:0] s);
        logic [DATA_BITS-1:0] shifted;
        logic                 in_window;
        in_window = (int'(idx) >= LEAD_ZEROS) && (int'(idx) < LEAD_ZEROS + DATA_BITS);
        shifted   = s << (int'(idx) - LEAD_ZEROS);
        return in_window & shifted[DATA_BITS-1];
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; a cs_n rise wins over a coincident sclk fall.
    always_comb begin
        // NOTE: state_next gets a default before the case so every path assigns it; a missing assignment in combinational logic infers a latch.
        state_next = state;
        case (state)
            ST_IDLE:  if (cs_fall) state_next = ST_SHIFT;
            ST_SHIFT: begin
                if (cs_rise) begin
                    state_next = ST_IDLE;
                end else if (sclk_fall && bit_idx == LAST_IDX) begin
                    state_next = ST_QUIET;
                end
            end
            ST_QUIET: if (cs_rise) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Frame events derived from state and synchronized edges.
    always_comb begin
        sdata_oe     = (state != ST_IDLE);
        frame_start  = (state == ST_IDLE) && cs_fall;
        frame_abort  = (state == ST_SHIFT) && cs_rise;
        shift_step   = (state == ST_SHIFT) && sclk_fall && !cs_rise;
        frame_finish = shift_step && (bit_idx == LAST_IDX);
        shifting     = (state == ST_SHIFT) && !cs_rise && !frame_finish;
    end

    // Sample capture, bit counter, registered serial data, counters and pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bit_idx     <= '0;
            sample_q    <= '0;
            ramp        <= '0;
            conv_count  <= '0;
            sdata       <= 1'b0;
            sample_ack  <= 1'b0;
            underrun    <= 1'b0;
            conv_done   <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            sample_ack  <= 1'b0;
            underrun    <= 1'b0;
            conv_done   <= frame_finish;
            frame_error <= frame_abort;

            if (frame_start) begin
                bit_idx <= '0;
                if (pattern_en) begin
                    sample_q <= ramp;
                end else if (sample_valid) begin
                    sample_q   <= sample_data;
                    sample_ack <= 1'b1;
                end else begin
                    underrun <= 1'b1;
                end
            end else if (shift_step) begin
                bit_idx <= bit_idx + BIT_IDX_W'(1);
            end

            if (frame_finish) begin
                conv_count <= conv_count + 16'd1;
                ramp       <= ramp + DATA_BITS'(1);
            end

            // Zero outside SHIFT keeps the line low while tristated and in QUIET.
            sdata <= shifting ? bit_at(bit_idx, sample_q) : 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder. The model works at frame level: it
// decides each frame's sample from the source rules, builds the expected
// 16-bit serial word, and keeps expected pulse totals and counters.
module tb_adc_spi_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        sclk;
    logic        cs_n;
    logic        sdata;
    logic        sdata_oe;
    logic [7:0]  sample_data;
    logic        sample_valid;
    logic        sample_ack;
    logic        pattern_en;
    logic        conv_done;
    logic [15:0] conv_count;
    logic        underrun;
    logic        frame_error;

    adc_spi_responder dut (
        .clk          (clk),
        .reset        (reset),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .sdata        (sdata),
        .sdata_oe     (sdata_oe),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ack   (sample_ack),
        .pattern_en   (pattern_en),
        .conv_done    (conv_done),
        .conv_count   (conv_count),
        .underrun     (underrun),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Frame-level model state.
    logic [15:0] m_count;
    logic [7:0]  m_ramp;
    logic [7:0]  m_last;
    logic [15:0] exp_word;
    int exp_ack = 0, exp_under = 0, exp_done = 0, exp_ferr = 0;

    // Pulses observed on the DUT.
    int n_ack = 0, n_under = 0, n_done = 0, n_ferr = 0;
    logic p_ack = 1'b0, p_under = 1'b0, p_done = 1'b0, p_ferr = 1'b0;

    function automatic logic [15:0] frame_word(input logic [7:0] s);
        return {3'b000, s, 5'b00000};
    endfunction

    // Per-cycle monitor: pulse counting, pulse width, and quiet line while tristated.
    always @(negedge clk) begin
        if (reset) begin
            if (sdata_oe === 1'b0) check("tristate_sdata_zero", sdata, 0);
            if (sample_ack)  begin n_ack++;   check("ack_width",   p_ack,   0); end
            if (underrun)    begin n_under++; check("under_width", p_under, 0); end
            if (conv_done)   begin n_done++;  check("done_width",  p_done,  0); end
            if (frame_error) begin n_ferr++;  check("ferr_width",  p_ferr,  0); end
        end
        p_ack   = sample_ack;
        p_under = underrun;
        p_done  = conv_done;
        p_ferr  = frame_error;
    end

    task automatic model_reset();
        m_count = 16'd0;
        m_ramp  = 8'd0;
        m_last  = 8'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        cs_n  = 1'b1;
        sclk  = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
    endtask

    task automatic start_frame();
        logic [7:0] s;
        if (pattern_en) begin
            s = m_ramp;
        end else if (sample_valid) begin
            s = sample_data;
            exp_ack++;
        end else begin
            s = m_last;
            exp_under++;
        end
        m_last   = s;
        exp_word = frame_word(s);
        cs_n = 1'b0;
        #50;
    endtask

    task automatic shift_bits(input int n, output logic [15:0] seen);
        seen = '0;
        for (int i = 0; i < n; i++) begin
            check("shift_oe", sdata_oe, 1);
            check("shift_bit", sdata, exp_word[15-i]);
            seen[15-i] = sdata;
            sclk = 1'b0;
            #50;
            sclk = 1'b1;
            #50;
        end
    endtask

    task automatic end_frame(input bit full);
        if (full) begin
            check("quiet_sdata", sdata, 0);
            check("quiet_oe", sdata_oe, 1);
            m_count  = m_count + 16'd1;
            m_ramp   = m_ramp + 8'd1;
            exp_done++;
        end else begin
            exp_ferr++;
        end
        cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("end_oe_low", sdata_oe, 0);
        check("end_sdata", sdata, 0);
        repeat (5) @(negedge clk);
        check("ack_total",   n_ack,   exp_ack);
        check("under_total", n_under, exp_under);
        check("done_total",  n_done,  exp_done);
        check("ferr_total",  n_ferr,  exp_ferr);
        check("conv_count",  conv_count, m_count);
    endtask

    task automatic full_frame(output logic [15:0] seen);
        start_frame();
        shift_bits(16, seen);
        end_frame(1'b1);
    endtask

    logic [15:0] seen;

    initial begin
        reset        = 1'b0;
        sclk         = 1'b1;
        cs_n         = 1'b1;
        sample_valid = 1'b0;
        pattern_en   = 1'b0;
        sample_data  = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_sdata_oe",    sdata_oe,    0);
        check("rst_sdata",       sdata,       0);
        check("rst_conv_count",  conv_count,  0);
        check("rst_conv_done",   conv_done,   0);
        check("rst_sample_ack",  sample_ack,  0);
        check("rst_underrun",    underrun,    0);
        check("rst_frame_error", frame_error, 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Host sample A5.
        sample_data  = 8'hA5;
        sample_valid = 1'b1;
        full_frame(seen);
        check("a5_bits_literal",  seen, 16'b000_10100101_00000);
        check("a5_count_literal", conv_count, 1);
        check("a5_ack_literal",   n_ack, 1);
        check("a5_done_literal",  n_done, 1);

        // 3C frame followed by an underrun frame repeating 3C.
        sample_data = 8'h3C;
        full_frame(seen);
        sample_valid = 1'b0;
        sample_data  = 8'hFF;
        full_frame(seen);
        check("underrun_bits_literal",  seen, 16'b000_00111100_00000);
        check("underrun_pulse_literal", n_under, 1);
        check("underrun_ack_literal",   n_ack, 2);

        // Aborted frame after 7 falls, then a clean frame.
        sample_valid = 1'b1;
        sample_data  = 8'h5A;
        start_frame();
        shift_bits(7, seen);
        end_frame(1'b0);
        check("abort_ferr_literal",  n_ferr, 1);
        check("abort_count_literal", conv_count, 3);
        sample_data = 8'hC3;
        full_frame(seen);
        check("after_abort_literal", seen, 16'b000_11000011_00000);

        // Reset at bit_idx 5: frame dropped, counters cleared, no frame_error.
        sample_data = 8'h96;
        start_frame();
        shift_bits(5, seen);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_oe",    sdata_oe,   0);
        check("midrst_count", conv_count, 0);
        @(negedge clk);
        cs_n = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        check("midrst_no_ferr", n_ferr, exp_ferr);
        sample_data = 8'h81;
        full_frame(seen);
        check("after_rst_literal", seen, 16'b000_10000001_00000);
        check("after_rst_count",   conv_count, 1);

        // Ramp: 258 frames from reset, data wraps 255 -> 0.
        do_reset();
        pattern_en = 1'b1;
        for (int f = 0; f < 258; f++) begin
            full_frame(seen);
            if (f == 255) check("ramp_255_literal", seen, 16'b000_11111111_00000);
        end
        check("ramp_last_literal",  seen, 16'b000_00000001_00000);
        check("ramp_count_literal", conv_count, 258);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
